mem_arbiter: RTL and testbench

- Sequences the single unified instruction/data memory and shares it between two requesters: the core (fetch/load/store) and an auxiliary port (program loader / debug).
- Performs round-robin arbitration, address alignment and range checks, load byte/half extraction with sign/zero extension, and read-modify-write for sb/sh, because the memory has no byte enables.
- Sits between the requesters and the memory's A/WD/WE/RD pins.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and memory pins of the unified memory arbiter, bundled as one interface.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
    logic        c_req;
    logic        c_we;
    logic [2:0]  c_funct3;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_done;
    logic        c_err;
    logic [31:0] c_rdata;

    logic        a_req;
    logic        a_we;
    logic [2:0]  a_funct3;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_done;
    logic        a_err;
    logic [31:0] a_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  c_req, c_we, c_funct3, c_addr, c_wdata,
        output c_done, c_err, c_rdata,
        input  a_req, a_we, a_funct3, a_addr, a_wdata,
        output a_done, a_err, a_rdata,
        output mem_addr, mem_wd, mem_we,
        input  mem_rd
    );

    modport master (
        output c_req, c_we, c_funct3, c_addr, c_wdata,
        input  c_done, c_err, c_rdata,
        output a_req, a_we, a_funct3, a_addr, a_wdata,
        input  a_done, a_err, a_rdata,
        input  mem_addr, mem_wd, mem_we,
        output mem_rd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for a single word-wide memory without byte enables, shared
// by the core and an aux port; does load extraction and read-modify-write for sb/sh.
module mem_arbiter #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam int   NUM_PORTS = 2;
    localparam logic CORE      = 1'b0;
    localparam logic AUX       = 1'b1;

    logic [NUM_PORTS-1:0]        req_v;
    req_t [NUM_PORTS-1:0]        req_in;
    logic [NUM_PORTS-1:0]        done_q, err_q;
    logic [NUM_PORTS-1:0][31:0]  rdata_q;

    state_t      state, state_nx;
    logic        owner, owner_nx, last_owner, grant;
    req_t        cur;
    logic [31:0] merge_q;

    logic [1:0]  size;
    logic        f3_ok, misal, oor, req_err, we_raw;
    logic [31:0] word_addr, load_val, merged, mem_addr, mem_wd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req_v        = {bus.a_req, bus.c_req};
    assign req_in[CORE] = {bus.c_we, bus.c_funct3, bus.c_addr, bus.c_wdata};
    assign req_in[AUX]  = {bus.a_we, bus.a_funct3, bus.a_addr, bus.a_wdata};

    // Everything below works off the latched request, so requester inputs may move freely.
    always_comb begin
        size      = cur.funct3[1:0];
        f3_ok     = cur.we ? (cur.funct3 inside {3'b000, 3'b001, 3'b010})
                           : (cur.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal     = (size == 2'b01 && cur.addr[0]) || (size == 2'b10 && cur.addr[1:0] != 2'b00);
        oor       = cur.addr >= MEM_SIZE;
        req_err   = !f3_ok || misal || oor;
        word_addr = {cur.addr[31:2], 2'b00};

        ld_byte = bus.mem_rd[{cur.addr[1:0], 3'b000} +: 8];
        ld_half = cur.addr[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
        case (size)
            2'b00:   load_val = cur.funct3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_val = cur.funct3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_val = bus.mem_rd;
        endcase

        merged = bus.mem_rd;
        if (size == 2'b00)
            merged[{cur.addr[1:0], 3'b000} +: 8] = cur.wdata[7:0];
        else
            merged[{cur.addr[1], 4'b0000} +: 16] = cur.wdata[15:0];
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        grant    = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        we_raw   = 1'b0;
        case (state)
            IDLE: begin
                if (|req_v) begin
                    grant    = 1'b1;
                    owner_nx = (&req_v) ? ~last_owner : req_v[AUX];
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = word_addr;
                if (req_err || !cur.we) begin
                    state_nx = DONE;
                end else if (size == 2'b10) begin
                    we_raw   = 1'b1;
                    mem_wd   = cur.wdata;
                    state_nx = DONE;
                end else begin
                    state_nx = MERGE_WR;
                end
            end
            MERGE_WR: begin
                mem_addr = word_addr;
                we_raw   = 1'b1;
                mem_wd   = merge_q;
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= CORE;
            last_owner <= AUX;
            cur        <= '0;
            merge_q    <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            done_q <= '0;
            err_q  <= '0;
            if (grant)
                cur <= req_in[owner_nx];
            if (state == ACCESS && !req_err && cur.we && size != 2'b10)
                merge_q <= merged;
            if (state == DONE)
                last_owner <= owner;
            // Outputs are loaded on entry to DONE so they are valid for the whole DONE cycle.
            if (state_nx == DONE) begin
                done_q[owner]  <= 1'b1;
                err_q[owner]   <= req_err;
                rdata_q[owner] <= (state == ACCESS && !req_err && !cur.we) ? load_val : '0;
            end
        end
    end

    // Write enable is gated by reset so an aborted store never reaches memory.
    assign bus.mem_addr = mem_addr;
    assign bus.mem_wd   = mem_wd;
    assign bus.mem_we   = we_raw & ~reset;

    assign bus.c_done  = done_q[CORE];
    assign bus.c_err   = err_q[CORE];
    assign bus.c_rdata = rdata_q[CORE];
    assign bus.a_done  = done_q[AUX];
    assign bus.a_err   = err_q[AUX];
    assign bus.a_rdata = rdata_q[AUX];
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus random traffic checked
// against a byte-addressed memory model and the round-robin grant rule.
module tb_mem_arbiter;
    localparam int MEM_SIZE = 1024;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] mem [0:255];
    logic [7:0]  rmem [0:MEM_SIZE-1];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_w;
    logic [31:0] poke_d;

    assign bus.mem_rd = mem[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wd;
        if (poke_en)    mem[poke_w] <= poke_d;
    end

    int          vectors = 0, miscompares = 0;
    bit          last_aux;
    logic [31:0] hold [2];
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int addr, input logic [31:0] d);
        poke_en = 1'b1; poke_w = 8'(addr >> 2); poke_d = d;
        for (int i = 0; i < 4; i++) rmem[(addr & ~3) + i] = d[8*i +: 8];
        @(posedge clk); #1 poke_en = 1'b0;
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int a;
        a = int'(addr & 32'h3FC);
        return {rmem[a+3], rmem[a+2], rmem[a+1], rmem[a]};
    endfunction

    task automatic drive(input int p, input bit req, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (p == 0) begin
            bus.c_req = req; bus.c_we = we; bus.c_funct3 = f3; bus.c_addr = addr; bus.c_wdata = wd;
        end else begin
            bus.a_req = req; bus.a_we = we; bus.a_funct3 = f3; bus.a_addr = addr; bus.a_wdata = wd;
        end
    endtask

    function automatic logic get_done(input int p);  return p == 0 ? bus.c_done  : bus.a_done;  endfunction
    function automatic logic get_err(input int p);   return p == 0 ? bus.c_err   : bus.a_err;   endfunction
    function automatic logic [31:0] get_rdata(input int p); return p == 0 ? bus.c_rdata : bus.a_rdata; endfunction

    // Reference: byte memory, little-endian assembly, arithmetic sign extension.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output bit err, output logic [31:0] rd,
                         output int lat, output int nwe);
        int nb;
        bit ok;
        ok  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nb  = 1 << f3[1:0];
        err = !ok || (addr % 32'(nb) != 0) || (addr >= 32'(MEM_SIZE));
        rd  = '0; lat = 2; nwe = 0;
        if (err) return;
        if (!we) begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = rmem[int'(addr) + i];
            if (!f3[2] && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8*nb));
        end else begin
            for (int i = 0; i < nb; i++) rmem[int'(addr) + i] = wd[8*i +: 8];
            nwe = 1;
            lat = (nb == 4) ? 2 : 3;
        end
    endtask

    task automatic rand_op(output bit we, output logic [2:0] f3, output logic [31:0] addr,
                           output logic [31:0] wd);
        int lst [5] = '{0, 1, 2, 4, 5};
        int k, nb;
        we = 1'($urandom_range(0, 1));
        k  = $urandom_range(0, 15);
        if (k == 0)      f3 = we ? 3'($urandom_range(3, 7)) : 3'($urandom_range(6, 7));
        else if (k == 1) f3 = 3'b011;
        else if (we)     f3 = 3'($urandom_range(0, 2));
        else             f3 = 3'(lst[$urandom_range(0, 4)]);
        nb   = 1 << f3[1:0];
        addr = $urandom_range(0, MEM_SIZE - 1);
        addr = addr & ~32'(nb - 1);
        k    = $urandom_range(0, 15);
        if (k == 0) addr = addr + 32'(MEM_SIZE) + 32'($urandom_range(0, 3) * 4);
        if (k == 1) addr = addr | 32'd1;
        wd = $urandom;
    endtask

    task automatic run_txn(input int p, input bit we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        bit eerr, seen;
        logic [31:0] erd;
        int elat, enwe, cyc, nwe;
        model(we, f3, addr, wd, eerr, erd, elat, enwe);
        drive(p, 1'b1, we, f3, addr, wd);
        cyc = 0; nwe = 0; seen = 0;
        while (!seen && cyc < 8) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (bus.mem_we) nwe++;
            if (get_done(p)) seen = 1;
        end
        check("latency", 32'(cyc), 32'(elat));
        check("err", 32'(get_err(p)), 32'(eerr));
        check("rdata", get_rdata(p), erd);
        check("other_done", 32'(get_done(1 - p)), 32'd0);
        check("other_rdata_hold", get_rdata(1 - p), hold[1 - p]);
        check("we_cycles", 32'(nwe), 32'(enwe));
        if (we && !eerr) check("mem_word", mem[addr[9:2]], ref_word(addr));
        last_rdata = get_rdata(p);
        hold[p] = erd;
        last_aux = (p == 1);
        @(posedge clk); #1 drive(p, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        @(negedge clk);
        check("done_one_cycle", 32'(get_done(p)), 32'd0);
    endtask

    // Both ports request together and keep requesting; grants must alternate.
    task automatic conflict(input int rounds);
        bit pw [2];
        logic [2:0] pf [2];
        logic [31:0] pa [2], pd [2];
        int exp_w, w, cyc, mlat, mnwe;
        bit seen, merr;
        logic [31:0] mrd;
        for (int p = 0; p < 2; p++) begin
            rand_op(pw[p], pf[p], pa[p], pd[p]);
            drive(p, 1'b1, pw[p], pf[p], pa[p], pd[p]);
        end
        exp_w = last_aux ? 0 : 1;
        w = 0;
        for (int r = 0; r < rounds; r++) begin
            cyc = 0; seen = 0;
            while (!seen && cyc < 12) begin
                @(posedge clk); cyc++;
                if (cyc == 1 && r > 0) begin
                    #1 rand_op(pw[w], pf[w], pa[w], pd[w]);
                    drive(w, 1'b1, pw[w], pf[w], pa[w], pd[w]);
                end
                @(negedge clk);
                if (bus.c_done || bus.a_done) seen = 1;
            end
            w = bus.a_done ? 1 : 0;
            check("conf_owner", 32'(w), 32'(exp_w));
            check("conf_both_done", 32'(bus.c_done & bus.a_done), 32'd0);
            model(pw[w], pf[w], pa[w], pd[w], merr, mrd, mlat, mnwe);
            check("conf_latency", 32'(cyc), 32'(r == 0 ? mlat : mlat + 1));
            check("conf_err", 32'(get_err(w)), 32'(merr));
            check("conf_rdata", get_rdata(w), mrd);
            check("conf_other_hold", get_rdata(1 - w), hold[1 - w]);
            hold[w]  = mrd;
            last_aux = (w == 1);
            exp_w    = 1 - w;
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        drive(1, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        @(negedge clk);
    endtask

    initial begin
        int bad;
        bit rw;
        logic [2:0] rf;
        logic [31:0] ra, rd;
        drive(0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        drive(1, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        reset = 1'b1;
        for (int i = 0; i < 256; i++) poke(i * 4, $urandom);
        @(negedge clk);
        check("rst_c_done", 32'(bus.c_done), 32'd0);
        check("rst_a_done", 32'(bus.a_done), 32'd0);
        check("rst_c_err", 32'(bus.c_err), 32'd0);
        check("rst_c_rdata", bus.c_rdata, 32'd0);
        check("rst_a_rdata", bus.a_rdata, 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_mem_addr", bus.mem_addr, 32'd0);
        last_aux = 1'b1;
        hold[0] = '0; hold[1] = '0;

        poke(32'h10, 32'hDEADBEEF);
        run_txn(0, 1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_const", last_rdata, 32'hDEADBEEF);
        poke(32'h10, 32'h80FF7F01);
        run_txn(0, 1'b0, 3'b000, 32'h13, 32'h0);
        check("lb_const", last_rdata, 32'hFFFFFF80);
        run_txn(0, 1'b0, 3'b100, 32'h13, 32'h0);
        check("lbu_const", last_rdata, 32'h00000080);
        poke(32'h20, 32'h11223344);
        run_txn(1, 1'b1, 3'b000, 32'h21, 32'h000000AA);
        check("sb_const", mem[8], 32'h1122AA44);
        run_txn(0, 1'b1, 3'b001, 32'h03, 32'h1234);
        run_txn(0, 1'b0, 3'b010, 32'h402, 32'h0);
        run_txn(0, 1'b0, 3'b011, 32'h00, 32'h0);

        // Abort an sh in its merge-write cycle; the core ran last, so a stale owner would favour aux.
        poke(32'h40, 32'hCAFEF00D);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 3'b001, 32'h40, 32'h0000BEEF);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        @(negedge clk);
        check("rst_merge_we", 32'(bus.mem_we), 32'd0);
        check("rst_merge_done", 32'(bus.c_done | bus.a_done), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_idle_addr", bus.mem_addr, 32'd0);
        check("rst_no_done", 32'(bus.c_done | bus.a_done), 32'd0);
        check("rst_mem_unchanged", mem[16], 32'hCAFEF00D);
        last_aux = 1'b1;
        hold[0] = '0; hold[1] = '0;
        conflict(3);

        for (int i = 0; i < 40; i++) begin
            rand_op(rw, rf, ra, rd);
            run_txn(int'($urandom_range(0, 1)), rw, rf, ra, rd);
        end
        for (int i = 0; i < 4; i++) conflict(int'($urandom_range(2, 5)));

        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_word(32'(i * 4))) bad++;
        check("mem_final", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
